board_renderer: RTL and testbench

- Parametrised successor to the fixed-size painter path in the game's low-level display layer.
- Walks an arbitrary BOARD_W x BOARD_H board and emits one pixel write per cycle (coordinates, colour, plot strobe) towards the frame-buffer adapter.
- Supports full redraw and incremental redraw; incremental mode repaints only cells whose stone, pointer highlight or win state changed since the last frame.
- Sits between game logic (board, gaming status, pointer) and vga_adapter.

---
 rtl/board_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_board_renderer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// Board painter for the frame-buffer adapter. It walks the board cell by cell and emits one pixel
// write per cycle. Cells that match the shadow copy of the last frame are skipped.
module board_renderer #(
  parameter int unsigned BOARD_W     = 15,
  parameter int unsigned BOARD_H     = 15,
  parameter int unsigned CELL_PX     = 8,
  parameter int unsigned X_OFFSET    = 20,
  parameter int unsigned Y_OFFSET    = 0,
  parameter int unsigned SCR_X_BITS  = 8,
  parameter int unsigned SCR_Y_BITS  = 7,
  parameter int unsigned COLOUR_BITS = 3,
  parameter logic [COLOUR_BITS-1:0] COL_BG   = 3'b110,
  parameter logic [COLOUR_BITS-1:0] COL_GRID = 3'b000,
  parameter logic [COLOUR_BITS-1:0] COL_A    = 3'b000,
  parameter logic [COLOUR_BITS-1:0] COL_B    = 3'b111,
  parameter logic [COLOUR_BITS-1:0] COL_PTR  = 3'b100,
  localparam int unsigned XB = $clog2(BOARD_W),
  localparam int unsigned YB = $clog2(BOARD_H)
) (
  input  logic                     Clck,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     full_redraw,
  input  logic [2*BOARD_W*BOARD_H-1:0] board,
  input  logic [1:0]               gaming_status,
  input  logic [XB-1:0]            pointer_loc_x,
  input  logic [YB-1:0]            pointer_loc_y,
  output logic [SCR_X_BITS-1:0]    paint_x_co,
  output logic [SCR_Y_BITS-1:0]    paint_y_co,
  output logic [COLOUR_BITS-1:0]   color,
  output logic                     print_enable,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NCELL = BOARD_W * BOARD_H;
  localparam int unsigned IB    = $clog2(NCELL);
  localparam int unsigned PB    = $clog2(CELL_PX);

  typedef enum logic [1:0] {StIdle, StScan, StDraw, StFin} state_e;

  state_e state_q, state_d;

  logic [2*NCELL-1:0] snap_board_q, shadow_board_q;
  logic [1:0]         snap_status_q, shadow_status_q;
  logic [XB-1:0]      snap_px_q, shadow_px_q;
  logic [YB-1:0]      snap_py_q, shadow_py_q;
  logic               shadow_valid_q, eff_full_q;
  logic [IB-1:0]      idx_q;
  logic [XB-1:0]      col_q;
  logic [YB-1:0]      row_q;
  logic [PB-1:0]      px_q, py_q;

  logic [1:0] cur_code, old_code;
  logic       ptr_moved, at_new, at_old, dirty;
  logic       last_cell, last_px, last_py, ring;
  logic [COLOUR_BITS-1:0] grid_col, stone_col, pix_col;

  assign cur_code  = snap_board_q[{idx_q, 1'b0} +: 2];
  assign old_code  = shadow_board_q[{idx_q, 1'b0} +: 2];
  assign ptr_moved = (snap_px_q != shadow_px_q) || (snap_py_q != shadow_py_q);
  // An out-of-range pointer never equals a live col/row, so it highlights and dirties nothing.
  assign at_new    = (col_q == snap_px_q) && (row_q == snap_py_q);
  assign at_old    = (col_q == shadow_px_q) && (row_q == shadow_py_q);
  assign dirty     = eff_full_q || (cur_code != old_code) || (ptr_moved && (at_new || at_old));
  assign last_cell = idx_q == IB'(NCELL - 1);
  assign last_px   = px_q == PB'(CELL_PX - 1);
  assign last_py   = py_q == PB'(CELL_PX - 1);
  assign ring      = (px_q == PB'(1)) || (px_q == PB'(CELL_PX - 1)) ||
                     (py_q == PB'(1)) || (py_q == PB'(CELL_PX - 1));

  always_comb begin
    grid_col = COL_GRID;
    unique case (snap_status_q)
      2'b01:   grid_col = COL_A;
      2'b10:   grid_col = COL_B;
      2'b11:   grid_col = COL_PTR;
      default: grid_col = COL_GRID;
    endcase
    stone_col = COL_BG;
    unique case (cur_code)
      2'b01:   stone_col = COL_A;
      2'b10:   stone_col = COL_B;
      default: stone_col = COL_BG;
    endcase
    if (px_q == '0 || py_q == '0) pix_col = grid_col;
    else if (at_new && ring)      pix_col = COL_PTR;
    else                          pix_col = stone_col;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StScan;
      StScan: begin
        if (dirty)          state_d = StDraw;
        else if (last_cell) state_d = StFin;
      end
      StDraw: if (last_px && last_py) state_d = last_cell ? StFin : StScan;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    print_enable = (state_q == StDraw);
    busy         = (state_q != StIdle);
    done         = (state_q == StFin);
    paint_x_co   = '0;
    paint_y_co   = '0;
    color        = '0;
    if (print_enable) begin
      paint_x_co = SCR_X_BITS'(X_OFFSET + 32'(col_q) * CELL_PX + 32'(px_q));
      paint_y_co = SCR_Y_BITS'(Y_OFFSET + 32'(row_q) * CELL_PX + 32'(py_q));
      color      = pix_col;
    end
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      snap_board_q    <= '0;
      snap_status_q   <= '0;
      snap_px_q       <= '0;
      snap_py_q       <= '0;
      eff_full_q      <= 1'b0;
      shadow_board_q  <= '0;
      shadow_status_q <= '0;
      shadow_px_q     <= '0;
      shadow_py_q     <= '0;
      shadow_valid_q  <= 1'b0;
      idx_q           <= '0;
      col_q           <= '0;
      row_q           <= '0;
      px_q            <= '0;
      py_q            <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          snap_board_q  <= board;
          snap_status_q <= gaming_status;
          snap_px_q     <= pointer_loc_x;
          snap_py_q     <= pointer_loc_y;
          eff_full_q    <= full_redraw | ~shadow_valid_q | (gaming_status != shadow_status_q);
          idx_q         <= '0;
          col_q         <= '0;
          row_q         <= '0;
        end
        StScan: begin
          if (dirty) begin
            px_q <= '0;
            py_q <= '0;
          end else if (!last_cell) begin
            idx_q <= idx_q + 1'b1;
            if (col_q == XB'(BOARD_W - 1)) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDraw: begin
          if (!last_px) begin
            px_q <= px_q + 1'b1;
          end else begin
            px_q <= '0;
            if (!last_py) begin
              py_q <= py_q + 1'b1;
            end else begin
              py_q <= '0;
              shadow_board_q[{idx_q, 1'b0} +: 2] <= cur_code;
              if (!last_cell) begin
                idx_q <= idx_q + 1'b1;
                if (col_q == XB'(BOARD_W - 1)) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
                end else begin
                  col_q <= col_q + 1'b1;
                end
              end
            end
          end
        end
        StFin: begin
          shadow_px_q     <= snap_px_q;
          shadow_py_q     <= snap_py_q;
          shadow_status_q <= snap_status_q;
          shadow_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: randomized frames checked against a pixel-list model of
// the board painter built from the cell/pixel rules.
module tb_board_renderer;

  localparam int W = 15, H = 15, CP = 8, XO = 20, YO = 0, NC = W * H;
  localparam logic [2:0] C_BG = 3'b110, C_GRID = 3'b000, C_A = 3'b000, C_B = 3'b111,
                         C_PTR = 3'b100;

  logic         Clck = 1'b0;
  logic         Reset = 1'b0;
  logic         start = 1'b0;
  logic         full_redraw = 1'b0;
  logic [2*NC-1:0] board = '0;
  logic [1:0]   gaming_status = 2'b00;
  logic [3:0]   pointer_loc_x = '0;
  logic [3:0]   pointer_loc_y = '0;
  logic [7:0]   paint_x_co;
  logic [6:0]   paint_y_co;
  logic [2:0]   color;
  logic         print_enable, busy, done;

  board_renderer u_dut (
    .Clck(Clck), .Reset(Reset), .start(start), .full_redraw(full_redraw), .board(board),
    .gaming_status(gaming_status), .pointer_loc_x(pointer_loc_x),
    .pointer_loc_y(pointer_loc_y), .paint_x_co(paint_x_co), .paint_y_co(paint_y_co),
    .color(color), .print_enable(print_enable), .busy(busy), .done(done)
  );

  always #5 Clck = ~Clck;

  int n_checks = 0;
  int n_fail = 0;

  // Model of what the screen last received.
  int m_board[NC];
  int m_ptr_x, m_ptr_y, m_status;
  bit m_valid;
  int s_board[NC];
  int s_ptr_x, s_ptr_y, s_status;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int busy_cnt, done_cnt, first_cyc, done_cyc, extra_done, extra_plots;

  function automatic logic [2:0] exp_colour(int c, int r, int px, int py, int code);
    if (px == 0 || py == 0)
      return (s_status == 1) ? C_A : (s_status == 2) ? C_B : (s_status == 3) ? C_PTR : C_GRID;
    if (c == s_ptr_x && r == s_ptr_y && (px == 1 || px == CP - 1 || py == 1 || py == CP - 1))
      return C_PTR;
    return (code == 1) ? C_A : (code == 2) ? C_B : C_BG;
  endfunction

  // Snapshot current inputs and list every pixel the frame should paint, in order.
  function automatic void build_expected(input bit full);
    bit eff, moved, dirty;
    int k;
    exp_q.delete();
    for (int i = 0; i < NC; i++) s_board[i] = int'(board[2*i +: 2]);
    s_ptr_x = int'(pointer_loc_x);
    s_ptr_y = int'(pointer_loc_y);
    s_status = int'(gaming_status);
    eff = full || !m_valid || (s_status != m_status);
    moved = (s_ptr_x != m_ptr_x) || (s_ptr_y != m_ptr_y);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        k = r * W + c;
        dirty = eff || (s_board[k] != m_board[k]) ||
                (moved && ((c == s_ptr_x && r == s_ptr_y) || (c == m_ptr_x && r == m_ptr_y)));
        if (dirty)
          for (int py = 0; py < CP; py++)
            for (int px = 0; px < CP; px++)
              exp_q.push_back({8'(XO + c * CP + px), 7'(YO + r * CP + py),
                               exp_colour(c, r, px, py, s_board[k])});
      end
  endfunction

  function automatic void commit_model();
    for (int i = 0; i < NC; i++) m_board[i] = s_board[i];
    m_ptr_x = s_ptr_x;
    m_ptr_y = s_ptr_y;
    m_status = s_status;
    m_valid = 1'b1;
  endfunction

  function automatic void reset_model();
    for (int i = 0; i < NC; i++) m_board[i] = 0;
    m_ptr_x = 0;
    m_ptr_y = 0;
    m_status = 0;
    m_valid = 1'b0;
  endfunction

  function automatic int stream_errs();
    int e = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                         : exp_q.size() - obs_q.size();
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic [2:0] find_pix(int x, int y);
    foreach (obs_q[i])
      if (obs_q[i][17:10] == 8'(x) && obs_q[i][9:3] == 7'(y)) return obs_q[i][2:0];
    return 3'bxxx;
  endfunction

  function automatic void set_cell(int c, int r, int code);
    board[2*(r*W+c) +: 2] = 2'(code);
  endfunction

  task automatic run_frame(input bit full, input int mid_start, input int change_at,
                           input int extra);
    obs_q.delete();
    busy_cnt = 0; done_cnt = 0; first_cyc = -1; done_cyc = -1; extra_done = 0; extra_plots = 0;
    @(negedge Clck);
    start = 1'b1;
    full_redraw = full;
    @(negedge Clck);
    start = 1'b0;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      if (print_enable) begin
        obs_q.push_back({paint_x_co, paint_y_co, color});
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && !busy) break;
      start = (cyc == mid_start);
      if (cyc == change_at)
        for (int i = 0; i < NC; i++) board[2*i +: 2] = 2'($urandom_range(0, 3));
      @(negedge Clck);
    end
    start = 1'b0;
    for (int i = 0; i < extra; i++) begin
      @(negedge Clck);
      if (done) extra_done++;
      if (print_enable) extra_plots++;
    end
  endtask

  task automatic test_reset();
    reset_model();
    Reset = 1'b0;
    repeat (2) @(negedge Clck);
    n_checks++;
    if ({print_enable, busy, done, paint_x_co, paint_y_co, color} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pe=%b busy=%b done=%b x=%0d y=%0d c=%b, want all 0",
               print_enable, busy, done, paint_x_co, paint_y_co, color);
    end
    Reset = 1'b1;
    @(negedge Clck);
  endtask

  task automatic test_full_first();
    int e;
    build_expected(1'b0);
    run_frame(1'b0, -1, -1, 0);
    commit_model();
    e = stream_errs();
    n_checks += 7;
    if (obs_q.size() != 14400) begin n_fail++; $display("FAIL first_plots: got %0d want 14400", obs_q.size()); end
    if (e != 0) begin n_fail++; $display("FAIL first_stream: %0d pixel differences, want 0", e); end
    if (busy_cnt != 225 + 14400 + 1) begin n_fail++; $display("FAIL first_busy: got %0d want 14626", busy_cnt); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL first_done: got %0d pulses want 1", done_cnt); end
    if (first_cyc != 2) begin n_fail++; $display("FAIL first_latency: got %0d want 2", first_cyc); end
    if (find_pix(20, 0) !== 3'b000) begin n_fail++; $display("FAIL pix_20_0: got %b want 000", find_pix(20, 0)); end
    if (find_pix(21, 1) !== 3'b100) begin n_fail++; $display("FAIL pix_21_1: got %b want 100", find_pix(21, 1)); end
    n_checks++;
    if (find_pix(30, 9) !== 3'b110) begin n_fail++; $display("FAIL pix_30_9: got %b want 110", find_pix(30, 9)); end
  endtask

  task automatic test_incremental();
    int e, xmin, xmax, ymin, ymax;
    set_cell(3, 2, 1);
    build_expected(1'b0);
    run_frame(1'b0, -1, -1, 0);
    commit_model();
    e = stream_errs();
    xmin = 255; xmax = 0; ymin = 255; ymax = 0;
    foreach (obs_q[i]) begin
      if (int'(obs_q[i][17:10]) < xmin) xmin = int'(obs_q[i][17:10]);
      if (int'(obs_q[i][17:10]) > xmax) xmax = int'(obs_q[i][17:10]);
      if (int'(obs_q[i][9:3]) < ymin) ymin = int'(obs_q[i][9:3]);
      if (int'(obs_q[i][9:3]) > ymax) ymax = int'(obs_q[i][9:3]);
    end
    n_checks += 5;
    if (obs_q.size() != 64) begin n_fail++; $display("FAIL inc_plots: got %0d want 64", obs_q.size()); end
    if (e != 0) begin n_fail++; $display("FAIL inc_stream: %0d pixel differences, want 0", e); end
    if (xmin != 44 || xmax != 51 || ymin != 16 || ymax != 23) begin
      n_fail++;
      $display("FAIL inc_window: got x %0d..%0d y %0d..%0d want x 44..51 y 16..23", xmin, xmax, ymin, ymax);
    end
    if (find_pix(47, 19) !== 3'b000) begin n_fail++; $display("FAIL pix_47_19: got %b want 000", find_pix(47, 19)); end
    if (find_pix(44, 19) !== 3'b000) begin n_fail++; $display("FAIL pix_44_19: got %b want 000", find_pix(44, 19)); end
    build_expected(1'b0);
    run_frame(1'b0, -1, -1, 0);
    commit_model();
    n_checks += 2;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL nochange_plots: got %0d want 0", obs_q.size()); end
    if (done_cyc != 226 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL nochange_done: got cycle %0d count %0d want cycle 226 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_pointer_move();
    int e;
    pointer_loc_x = 4'd1;
    build_expected(1'b0);
    run_frame(1'b0, -1, -1, 0);
    commit_model();
    e = stream_errs();
    n_checks += 4;
    if (obs_q.size() != 128) begin n_fail++; $display("FAIL ptr_plots: got %0d want 128", obs_q.size()); end
    if (e != 0) begin n_fail++; $display("FAIL ptr_stream: %0d pixel differences, want 0", e); end
    if (find_pix(21, 1) !== 3'b110) begin n_fail++; $display("FAIL ptr_old_cell: got %b want 110", find_pix(21, 1)); end
    if (find_pix(29, 1) !== 3'b100) begin n_fail++; $display("FAIL ptr_new_ring: got %b want 100", find_pix(29, 1)); end
  endtask

  task automatic test_status_forced();
    int bad;
    gaming_status = 2'b10;
    build_expected(1'b0);
    run_frame(1'b0, -1, -1, 0);
    commit_model();
    bad = 0;
    foreach (obs_q[i])
      if (((int'(obs_q[i][17:10]) - XO) % CP == 0 || (int'(obs_q[i][9:3]) - YO) % CP == 0) &&
          obs_q[i][2:0] !== 3'b111) bad++;
    n_checks += 3;
    if (obs_q.size() != 14400) begin n_fail++; $display("FAIL status_plots: got %0d want 14400", obs_q.size()); end
    if (stream_errs() != 0) begin n_fail++; $display("FAIL status_stream: %0d pixel differences, want 0", stream_errs()); end
    if (bad != 0) begin n_fail++; $display("FAIL status_grid: %0d grid pixels not 111, want 0", bad); end
  endtask

  task automatic test_reset_mid();
    gaming_status = 2'b00;
    @(negedge Clck);
    start = 1'b1;
    full_redraw = 1'b1;
    @(negedge Clck);
    start = 1'b0;
    repeat (40) @(negedge Clck);
    n_checks++;
    if (print_enable !== 1'b1) begin n_fail++; $display("FAIL mid_in_draw: got pe=%b want 1", print_enable); end
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if ({print_enable, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got pe=%b busy=%b done=%b want 000", print_enable, busy, done);
    end
    @(negedge Clck);
    Reset = 1'b1;
    reset_model();
    build_expected(1'b0);
    run_frame(1'b0, -1, -1, 0);
    commit_model();
    n_checks += 2;
    if (obs_q.size() != 14400) begin n_fail++; $display("FAIL post_reset_plots: got %0d want 14400", obs_q.size()); end
    if (stream_errs() != 0) begin n_fail++; $display("FAIL post_reset_stream: %0d pixel differences, want 0", stream_errs()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < int'($urandom_range(1, 6)); j++)
        set_cell($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 3));
      pointer_loc_x = 4'($urandom_range(0, 15));
      pointer_loc_y = 4'($urandom_range(0, 15));
      build_expected(1'b0);
      run_frame(1'b0, -1, -1, 0);
      commit_model();
      n_checks += 3;
      if (stream_errs() != 0) begin n_fail++; $display("FAIL rand%0d_stream: %0d pixel differences, want 0", it, stream_errs()); end
      if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt); end
      if (busy_cnt != NC + exp_q.size() + 1) begin
        n_fail++;
        $display("FAIL rand%0d_busy: got %0d want %0d", it, busy_cnt, NC + exp_q.size() + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_cell(5, 5, 2);
    set_cell(0, 14, 1);
    build_expected(1'b0);
    run_frame(1'b0, 30, 10, 300);
    commit_model();
    n_checks += 3;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL busy_start_stream: %0d pixel differences, want 0", stream_errs()); end
    if (done_cnt != 1 || extra_done != 0) begin
      n_fail++;
      $display("FAIL busy_start_done: got %0d+%0d pulses want 1+0", done_cnt, extra_done);
    end
    if (extra_plots != 0) begin n_fail++; $display("FAIL busy_start_plots: got %0d extra want 0", extra_plots); end
    build_expected(1'b0);
    run_frame(1'b0, NC + exp_q.size() + 1, -1, 300);
    commit_model();
    n_checks += 2;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL fin_start_stream: %0d pixel differences, want 0", stream_errs()); end
    if (extra_done != 0 || extra_plots != 0) begin
      n_fail++;
      $display("FAIL fin_start_ignored: got %0d done %0d plots after frame want 0 0", extra_done, extra_plots);
    end
  endtask

  initial begin
    test_reset();
    test_full_first();
    test_incremental();
    test_pointer_move();
    test_status_forced();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
